// File: rtl/scaler_pkg.sv
// Shared types for the scaler_v front-end controller: FSM states and the
// double-buffered configuration record.
package scaler_pkg;

    localparam int CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAIT_VS  = 2'd1,
        FRAME    = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [CNT_WIDTH_DEFAULT-1:0] line_in_size;
        logic [CNT_WIDTH_DEFAULT-1:0] scale_step;
    } cfg_t;

endpackage

// File: rtl/scaler_v_ctrl_cfg_shadow.sv
// Pending/active configuration registers: validates and clamps writes into
// pending, and copies pending to active only when the frame is committed.
module scaler_v_cfg_shadow
    import scaler_pkg::*;
#(
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_wr,
    input  logic [CNT_WIDTH_DEFAULT-1:0] cfg_line_in_size,
    input  logic [CNT_WIDTH_DEFAULT-1:0] cfg_scale_step,
    input  logic                         commit,
    output cfg_t                         active_o,
    output logic                         cfg_err_o
);

    localparam logic [CNT_WIDTH_DEFAULT-1:0] LINE_MAX_M1 = CNT_WIDTH_DEFAULT'(LINE_IN_SIZE_MAX - 1);
    localparam logic [CNT_WIDTH_DEFAULT-1:0] STEP_UNITY  = CNT_WIDTH_DEFAULT'(LINE_STEP);
    localparam cfg_t CFG_RESET = '{line_in_size: LINE_MAX_M1, scale_step: STEP_UNITY};

    cfg_t pending_q, pending_d;
    cfg_t active_q, active_d;
    logic cfg_err;

    // A zero step rejects the whole write; an oversize line is clamped but still accepted.
    always_comb begin
        pending_d = pending_q;
        cfg_err   = 1'b0;
        if (cfg_wr) begin
            if (cfg_scale_step == '0) begin
                cfg_err = 1'b1;
            end else begin
                pending_d.scale_step = cfg_scale_step;
                if (cfg_line_in_size > LINE_MAX_M1) begin
                    pending_d.line_in_size = LINE_MAX_M1;
                    cfg_err                = 1'b1;
                end else begin
                    pending_d.line_in_size = cfg_line_in_size;
                end
            end
        end
    end

    // Commit takes the registered pending value, so a same-cycle write lands one frame later.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = pending_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= CFG_RESET;
            active_q  <= CFG_RESET;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
        end
    end

    assign active_o  = active_q;
    assign cfg_err_o = cfg_err;

endmodule

// File: rtl/scaler_v_ctrl.sv
// Frame sequencer in front of scaler_v: turns level-coded sync into start pulses,
// gates video to whole frames, commits shadowed config at frame start and checks line lengths.
module scaler_v_ctrl
    import scaler_pkg::*;
#(
    parameter int PIXEL_WIDTH      = 8,
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 128,
    parameter int CNT_WIDTH        = CNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ctrl_en,
    input  logic                   cfg_wr,
    input  logic [CNT_WIDTH-1:0]   cfg_line_in_size,
    input  logic [CNT_WIDTH-1:0]   cfg_scale_step,
    input  logic                   err_clr,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic [CNT_WIDTH-1:0]   line_in_size_o,
    output logic [CNT_WIDTH-1:0]   scale_step_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [CNT_WIDTH-1:0]   frame_cnt_o,
    output logic [CNT_WIDTH-1:0]   line_cnt_o,
    output logic                   err_line_o,
    output logic                   err_cfg_o
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_state_t state_q, state_d;
    logic hs_in_q, vs_in_q;
    logic line_start, frame_start, frame_end;
    logic commit, cfg_err, line_err, in_frame_next;
    cfg_t active;

    logic [PIXEL_WIDTH-1:0] do_out_q, do_out_d;
    logic de_out_q, de_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic frame_done_q, frame_done_d;
    logic line_seen_q, line_seen_d;
    logic err_line_q, err_line_d, err_cfg_q, err_cfg_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH:0]   line_len_exp;

    scaler_v_cfg_shadow #(
        .LINE_IN_SIZE_MAX (LINE_IN_SIZE_MAX),
        .LINE_STEP        (LINE_STEP)
    ) u_cfg_shadow (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_wr           (cfg_wr),
        .cfg_line_in_size (cfg_line_in_size),
        .cfg_scale_step   (cfg_scale_step),
        .commit           (commit),
        .active_o         (active),
        .cfg_err_o        (cfg_err)
    );

    assign line_start   = hs_in_q & ~hs_i;
    assign frame_start  = ~vs_in_q & vs_i;
    assign frame_end    = vs_in_q & ~vs_i;
    assign line_len_exp = {1'b0, active.line_in_size} + 1'b1;

    // The first line_start of a frame has no preceding line to check, hence line_seen.
    always_comb begin
        state_d      = state_q;
        commit       = 1'b0;
        line_err     = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_seen_d  = line_seen_q;
        case (state_q)
            DISABLED: begin
                if (ctrl_en) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!ctrl_en) begin
                    state_d = DISABLED;
                end else if (frame_start) begin
                    state_d     = FRAME;
                    commit      = 1'b1;
                    line_cnt_d  = '0;
                    pix_cnt_d   = CNT_WIDTH'(de_i);
                    line_seen_d = line_start;
                end
            end
            FRAME: begin
                if (frame_end) begin
                    if (line_seen_q) begin
                        line_err   = ({1'b0, pix_cnt_q} != line_len_exp);
                        line_cnt_d = sat_inc(line_cnt_q);
                    end
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    state_d      = ctrl_en ? WAIT_VS : DISABLED;
                end else if (line_start) begin
                    if (line_seen_q) begin
                        line_err   = ({1'b0, pix_cnt_q} != line_len_exp);
                        line_cnt_d = sat_inc(line_cnt_q);
                    end
                    line_seen_d = 1'b1;
                    pix_cnt_d   = CNT_WIDTH'(de_i);
                end else if (de_i) begin
                    pix_cnt_d = sat_inc(pix_cnt_q);
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    // Video is gated by the state it will be registered into, so the frame_start
    // pixel already appears on the outputs; a simultaneous set beats err_clr.
    always_comb begin
        in_frame_next = (state_d == FRAME);
        do_out_d      = di_i;
        de_out_d      = de_i & in_frame_next;
        hs_out_d      = line_start & in_frame_next;
        vs_out_d      = frame_start & in_frame_next;
        err_line_d    = (err_line_q & ~err_clr) | line_err;
        err_cfg_d     = (err_cfg_q & ~err_clr) | cfg_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DISABLED;
            hs_in_q      <= 1'b0;
            vs_in_q      <= 1'b0;
            do_out_q     <= '0;
            de_out_q     <= 1'b0;
            hs_out_q     <= 1'b0;
            vs_out_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_seen_q  <= 1'b0;
            err_line_q   <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_in_q      <= hs_i;
            vs_in_q      <= vs_i;
            do_out_q     <= do_out_d;
            de_out_q     <= de_out_d;
            hs_out_q     <= hs_out_d;
            vs_out_q     <= vs_out_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_seen_q  <= line_seen_d;
            err_line_q   <= err_line_d;
            err_cfg_q    <= err_cfg_d;
        end
    end

    assign do_o           = do_out_q;
    assign de_o           = de_out_q;
    assign hs_o           = hs_out_q;
    assign vs_o           = vs_out_q;
    assign line_in_size_o = active.line_in_size;
    assign scale_step_o   = active.scale_step;
    assign busy_o         = (state_q == FRAME);
    assign frame_done_o   = frame_done_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign line_cnt_o     = line_cnt_q;
    assign err_line_o     = err_line_q;
    assign err_cfg_o      = err_cfg_q;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Directed bench for scaler_v_ctrl: frames of level-coded video with hand-computed
// pulse counts, config commit timing, line-length errors, enable and reset behaviour.
module tb_scaler_v_ctrl;

    localparam int PW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, ctrl_en, cfg_wr, err_clr, de_i, hs_i, vs_i;
    logic [PW-1:0] di_i;
    logic [CW-1:0] cfg_line_in_size, cfg_scale_step;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o, busy_o, frame_done_o, err_line_o, err_cfg_o;
    logic [CW-1:0] line_in_size_o, scale_step_o, frame_cnt_o, line_cnt_o;

    int checks = 0;
    int fails  = 0;

    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, done_cnt = 0;
    logic          snap_hs, snap_de;
    logic [PW-1:0] snap_do;
    logic [CW-1:0] snap_lis, snap_step;

    scaler_v_ctrl #(
        .PIXEL_WIDTH      (PW),
        .LINE_IN_SIZE_MAX (1024),
        .LINE_STEP        (128),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctrl_en          (ctrl_en),
        .cfg_wr           (cfg_wr),
        .cfg_line_in_size (cfg_line_in_size),
        .cfg_scale_step   (cfg_scale_step),
        .err_clr          (err_clr),
        .di_i             (di_i),
        .de_i             (de_i),
        .hs_i             (hs_i),
        .vs_i             (vs_i),
        .do_o             (do_o),
        .de_o             (de_o),
        .hs_o             (hs_o),
        .vs_o             (vs_o),
        .line_in_size_o   (line_in_size_o),
        .scale_step_o     (scale_step_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .frame_cnt_o      (frame_cnt_o),
        .line_cnt_o       (line_cnt_o),
        .err_line_o       (err_line_o),
        .err_cfg_o        (err_cfg_o)
    );

    // Pulse counters plus a snapshot of everything visible on the frame-start cycle.
    always @(negedge clk) begin
        if (hs_o) hs_cnt++;
        if (de_o) de_cnt++;
        if (frame_done_o) done_cnt++;
        if (vs_o) begin
            vs_cnt++;
            snap_hs   = hs_o;
            snap_de   = de_o;
            snap_do   = do_o;
            snap_lis  = line_in_size_o;
            snap_step = scale_step_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic vs);
        for (int i = 0; i < n; i++) begin
            de_i = 1'b0; hs_i = 1'b1; vs_i = vs;
            tick();
        end
    endtask

    task automatic send_line(input int width, input bit wr_first);
        for (int p = 0; p < width; p++) begin
            de_i = 1'b1; hs_i = 1'b0; vs_i = 1'b1;
            di_i = PW'(p + 64);
            cfg_wr = (wr_first && p == 0);
            tick();
        end
        cfg_wr = 1'b0;
        de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_frame(input int lines, input int width, input int short_idx);
        idle(3, 1'b0);
        for (int l = 0; l < lines; l++) send_line((l == short_idx) ? width - 1 : width, 1'b0);
        idle(3, 1'b0);
    endtask

    task automatic write_cfg(input int lis, input int step);
        cfg_line_in_size = CW'(lis);
        cfg_scale_step   = CW'(step);
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ctrl_en = 1'b0; cfg_wr = 1'b0; err_clr = 1'b0;
        cfg_line_in_size = '0; cfg_scale_step = '0;
        di_i = '0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
        tick(); tick();
        checks++; if (line_in_size_o !== 16'd1023) begin fails++; $display("[TB] FAIL reset_line_in_size: got %0d expected 1023", line_in_size_o); end
        checks++; if (scale_step_o !== 16'd128) begin fails++; $display("[TB] FAIL reset_scale_step: got %0d expected 128", scale_step_o); end
        checks++; if ({de_o, hs_o, vs_o, busy_o, frame_done_o, err_line_o, err_cfg_o} !== 7'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 0", {de_o, hs_o, vs_o, busy_o, frame_done_o, err_line_o, err_cfg_o}); end
        checks++; if (frame_cnt_o !== 16'd0 || line_cnt_o !== 16'd0) begin fails++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", frame_cnt_o, line_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        int h0, v0, d0, f0;
        write_cfg(23, 179);
        checks++; if (err_cfg_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_err_cfg: got %0d expected 0", err_cfg_o); end
        ctrl_en = 1'b1;
        idle(2, 1'b0);
        h0 = hs_cnt; v0 = vs_cnt; d0 = de_cnt; f0 = done_cnt;
        send_frame(24, 24, -1);
        checks++; if (vs_cnt - v0 != 1) begin fails++; $display("[TB] FAIL basic_vs_pulses: got %0d expected 1", vs_cnt - v0); end
        checks++; if (snap_hs !== 1'b1 || snap_de !== 1'b1) begin fails++; $display("[TB] FAIL basic_first_pixel_align: got hs=%0d de=%0d expected 1/1", snap_hs, snap_de); end
        checks++; if (snap_do !== 8'h40) begin fails++; $display("[TB] FAIL basic_first_pixel_data: got %0h expected 40", snap_do); end
        checks++; if (snap_lis !== 16'd23 || snap_step !== 16'd179) begin fails++; $display("[TB] FAIL basic_cfg_at_start: got %0d/%0d expected 23/179", snap_lis, snap_step); end
        checks++; if (hs_cnt - h0 != 24) begin fails++; $display("[TB] FAIL basic_hs_pulses: got %0d expected 24", hs_cnt - h0); end
        checks++; if (de_cnt - d0 != 576) begin fails++; $display("[TB] FAIL basic_de_count: got %0d expected 576", de_cnt - d0); end
        checks++; if (done_cnt - f0 != 1) begin fails++; $display("[TB] FAIL basic_frame_done: got %0d expected 1", done_cnt - f0); end
        checks++; if (frame_cnt_o !== 16'd1) begin fails++; $display("[TB] FAIL basic_frame_cnt: got %0d expected 1", frame_cnt_o); end
        checks++; if (line_cnt_o !== 16'd24) begin fails++; $display("[TB] FAIL basic_line_cnt: got %0d expected 24", line_cnt_o); end
        checks++; if (err_line_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_end_state: got err=%0d busy=%0d expected 0/0", err_line_o, busy_o); end
    endtask

    task automatic test_cfg_double_buffer();
        cfg_line_in_size = 16'd23; cfg_scale_step = 16'd128;
        idle(3, 1'b0);
        for (int l = 0; l < 24; l++) send_line(24, l == 3);
        idle(3, 1'b0);
        checks++; if (scale_step_o !== 16'd179) begin fails++; $display("[TB] FAIL dbuf_hold_midframe: got %0d expected 179", scale_step_o); end
        checks++; if (frame_cnt_o !== 16'd2) begin fails++; $display("[TB] FAIL dbuf_frame_cnt: got %0d expected 2", frame_cnt_o); end
        cfg_line_in_size = 16'd23; cfg_scale_step = 16'd200;
        idle(3, 1'b0);
        for (int l = 0; l < 24; l++) send_line(24, l == 0);
        idle(3, 1'b0);
        checks++; if (snap_step !== 16'd128) begin fails++; $display("[TB] FAIL dbuf_commit_next: got %0d expected 128", snap_step); end
        checks++; if (scale_step_o !== 16'd128) begin fails++; $display("[TB] FAIL dbuf_coincident_old: got %0d expected 128", scale_step_o); end
        send_frame(24, 24, -1);
        checks++; if (snap_step !== 16'd200) begin fails++; $display("[TB] FAIL dbuf_coincident_later: got %0d expected 200", snap_step); end
    endtask

    task automatic test_line_check();
        send_frame(24, 24, 5);
        checks++; if (err_line_o !== 1'b1) begin fails++; $display("[TB] FAIL line_short_detect: got %0d expected 1", err_line_o); end
        checks++; if (line_cnt_o !== 16'd24) begin fails++; $display("[TB] FAIL line_short_cnt: got %0d expected 24", line_cnt_o); end
        pulse_err_clr();
        checks++; if (err_line_o !== 1'b0) begin fails++; $display("[TB] FAIL line_err_clr: got %0d expected 0", err_line_o); end
        send_frame(24, 24, -1);
        checks++; if (err_line_o !== 1'b0) begin fails++; $display("[TB] FAIL line_clean_stays: got %0d expected 0", err_line_o); end
    endtask

    task automatic test_cfg_validation();
        write_cfg(2000, 179);
        checks++; if (err_cfg_o !== 1'b1) begin fails++; $display("[TB] FAIL cfg_clamp_err: got %0d expected 1", err_cfg_o); end
        send_frame(24, 24, -1);
        checks++; if (snap_lis !== 16'd1023 || snap_step !== 16'd179) begin fails++; $display("[TB] FAIL cfg_clamp_value: got %0d/%0d expected 1023/179", snap_lis, snap_step); end
        checks++; if (err_line_o !== 1'b1) begin fails++; $display("[TB] FAIL cfg_clamp_line_err: got %0d expected 1", err_line_o); end
        pulse_err_clr();
        checks++; if (err_cfg_o !== 1'b0 || err_line_o !== 1'b0) begin fails++; $display("[TB] FAIL cfg_err_clr: got %0d/%0d expected 0/0", err_cfg_o, err_line_o); end
        cfg_line_in_size = 16'd23; cfg_scale_step = 16'd0;
        cfg_wr = 1'b1; err_clr = 1'b1;
        tick();
        cfg_wr = 1'b0; err_clr = 1'b0;
        checks++; if (err_cfg_o !== 1'b1) begin fails++; $display("[TB] FAIL cfg_zero_step_set_wins: got %0d expected 1", err_cfg_o); end
        send_frame(2, 24, -1);
        checks++; if (snap_lis !== 16'd1023 || snap_step !== 16'd179) begin fails++; $display("[TB] FAIL cfg_zero_step_rejected: got %0d/%0d expected 1023/179", snap_lis, snap_step); end
        write_cfg(23, 179);
        pulse_err_clr();
        checks++; if (err_cfg_o !== 1'b0) begin fails++; $display("[TB] FAIL cfg_valid_write: got %0d expected 0", err_cfg_o); end
    endtask

    task automatic test_ctrl_en_drop();
        int h0, v0, d0;
        h0 = hs_cnt;
        idle(3, 1'b0);
        for (int l = 0; l < 24; l++) begin
            if (l == 10) ctrl_en = 1'b0;
            send_line(24, 1'b0);
        end
        idle(3, 1'b0);
        checks++; if (hs_cnt - h0 != 24) begin fails++; $display("[TB] FAIL en_drop_full_frame: got %0d expected 24", hs_cnt - h0); end
        checks++; if (frame_cnt_o !== 16'd9) begin fails++; $display("[TB] FAIL en_drop_frame_cnt: got %0d expected 9", frame_cnt_o); end
        h0 = hs_cnt; v0 = vs_cnt; d0 = de_cnt;
        send_frame(24, 24, -1);
        checks++; if (hs_cnt != h0 || vs_cnt != v0 || de_cnt != d0) begin fails++; $display("[TB] FAIL en_drop_gated: got %0d/%0d/%0d pulses expected 0/0/0", hs_cnt - h0, vs_cnt - v0, de_cnt - d0); end
        checks++; if (frame_cnt_o !== 16'd9 || busy_o !== 1'b0) begin fails++; $display("[TB] FAIL en_drop_frozen: got cnt=%0d busy=%0d expected 9/0", frame_cnt_o, busy_o); end
        ctrl_en = 1'b1;
        idle(2, 1'b0);
    endtask

    task automatic test_async_reset();
        int h0, v0;
        idle(3, 1'b0);
        for (int l = 0; l < 5; l++) send_line(24, 1'b0);
        checks++; if (busy_o !== 1'b1) begin fails++; $display("[TB] FAIL rst_busy_before: got %0d expected 1", busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({de_o, hs_o, vs_o, busy_o, frame_done_o, err_line_o, err_cfg_o} !== 7'b0 || do_o !== 8'h00) begin fails++; $display("[TB] FAIL rst_mid_flags: got %b/%0h expected 0/0", {de_o, hs_o, vs_o, busy_o, frame_done_o, err_line_o, err_cfg_o}, do_o); end
        checks++; if (frame_cnt_o !== 16'd0 || line_cnt_o !== 16'd0) begin fails++; $display("[TB] FAIL rst_mid_counters: got %0d/%0d expected 0/0", frame_cnt_o, line_cnt_o); end
        checks++; if (line_in_size_o !== 16'd1023 || scale_step_o !== 16'd128) begin fails++; $display("[TB] FAIL rst_mid_cfg: got %0d/%0d expected 1023/128", line_in_size_o, scale_step_o); end
        @(negedge clk);
        rst_n = 1'b1;
        h0 = hs_cnt; v0 = vs_cnt;
        for (int l = 5; l < 24; l++) send_line(24, 1'b0);
        idle(3, 1'b0);
        checks++; if (hs_cnt != h0 || vs_cnt != v0 || frame_cnt_o !== 16'd0) begin fails++; $display("[TB] FAIL rst_release_quiet: got hs=%0d vs=%0d cnt=%0d expected 0/0/0", hs_cnt - h0, vs_cnt - v0, frame_cnt_o); end
        send_frame(24, 24, -1);
        checks++; if (vs_cnt - v0 != 1 || frame_cnt_o !== 16'd1) begin fails++; $display("[TB] FAIL rst_next_frame: got vs=%0d cnt=%0d expected 1/1", vs_cnt - v0, frame_cnt_o); end
        checks++; if (snap_lis !== 16'd1023 || snap_step !== 16'd128) begin fails++; $display("[TB] FAIL rst_next_cfg: got %0d/%0d expected 1023/128", snap_lis, snap_step); end
        checks++; if (err_line_o !== 1'b1) begin fails++; $display("[TB] FAIL rst_next_line_err: got %0d expected 1", err_line_o); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cfg_double_buffer();
        test_line_check();
        test_cfg_validation();
        test_ctrl_en_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
